// File: rtl/crossword_pkg.sv
`default_nettype none
// ============================================================================
// Module   : crossword_pkg
// Brief    : Keycodes, key classes and state encodings for the crossword cursor.
// Revision : 1.0
// ============================================================================
package crossword_pkg;

    localparam logic [7:0] KEY_NONE      = 8'h00;
    localparam logic [7:0] KEY_RIGHT     = 8'h4F;
    localparam logic [7:0] KEY_LEFT      = 8'h50;
    localparam logic [7:0] KEY_DOWN      = 8'h51;
    localparam logic [7:0] KEY_UP        = 8'h52;
    localparam logic [7:0] KEY_SPACE     = 8'h2C;
    localparam logic [7:0] KEY_LETTER_A  = 8'h04;
    localparam logic [7:0] KEY_LETTER_Z  = 8'h1D;
    localparam logic [7:0] KEY_BACKSPACE = 8'h2A;

    localparam int HL_W = 10;

    typedef enum logic {
        ACROSS = 1'b0,
        DOWN   = 1'b1
    } dir_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } key_state_t;

    typedef enum logic [2:0] {
        KC_NONE   = 3'd0,
        KC_RIGHT  = 3'd1,
        KC_LEFT   = 3'd2,
        KC_DOWN   = 3'd3,
        KC_UP     = 3'd4,
        KC_SPACE  = 3'd5,
        KC_LETTER = 3'd6,
        KC_BACK   = 3'd7
    } key_class_t;

    function automatic key_class_t decode_key(input logic [7:0] kc);
        key_class_t c;
        c = KC_NONE;
        if (kc == KEY_RIGHT)                               c = KC_RIGHT;
        else if (kc == KEY_LEFT)                           c = KC_LEFT;
        else if (kc == KEY_DOWN)                           c = KC_DOWN;
        else if (kc == KEY_UP)                             c = KC_UP;
        else if (kc == KEY_SPACE)                          c = KC_SPACE;
        else if (kc == KEY_BACKSPACE)                      c = KC_BACK;
        else if (kc >= KEY_LETTER_A && kc <= KEY_LETTER_Z) c = KC_LETTER;
        return c;
    endfunction

    function automatic logic is_arrow(input key_class_t c);
        return (c == KC_RIGHT) || (c == KC_LEFT) || (c == KC_DOWN) || (c == KC_UP);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cursor_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : cursor_ctrl_if
// Brief    : Keyboard-in / cursor-out bundle for cursor_ctrl.
// Revision : 1.0
// ============================================================================
interface cursor_ctrl_if #(
    parameter int COL_W = 4,
    parameter int ROW_W = 4
);
    logic [7:0]       keycode;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [9:0]       highlightX;
    logic [9:0]       highlightY;
    logic             dir;
    logic             move_pulse;

    modport master (
        output keycode,
        input  col, row, highlightX, highlightY, dir, move_pulse
    );

    modport slave (
        input  keycode,
        output col, row, highlightX, highlightY, dir, move_pulse
    );
endinterface
`default_nettype wire

// File: rtl/key_repeat.sv
`default_nettype none
// ============================================================================
// Module   : key_repeat
// Brief    : Keycode edge detect and arrow auto-repeat; emits a step strobe
//            together with the decoded class of the current key.
// Revision : 1.0
// ============================================================================
module key_repeat
    import crossword_pkg::*;
#(
    parameter int REPEAT_DELAY = 30,
    parameter int REPEAT_RATE  = 6
) (
    input  wire logic       frame_clk,
    input  wire logic       Reset_n,
    input  wire logic [7:0] keycode,
    output logic            step,
    output key_class_t      key_class
);

    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

    key_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       prev_q, prev_d;

    key_class_t w_class;
    logic [7:0] w_kc;
    logic       w_press;
    logic       w_held;

    // Unrecognised codes are folded to 0 so they neither press nor hold.
    assign w_class = decode_key(keycode);
    assign w_kc    = (w_class == KC_NONE) ? KEY_NONE : keycode;
    assign w_press = (w_kc != prev_q) && (w_class != KC_NONE);
    assign w_held  = (w_kc == prev_q) && (w_class != KC_NONE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prev_d  = w_kc;
        step    = 1'b0;
        if (w_press) begin
            step    = 1'b1;
            cnt_d   = '0;
            state_d = is_arrow(w_class) ? DELAY : IDLE;
        end else if (!w_held) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                DELAY: begin
                    if (cnt_q == DELAY_LAST) begin
                        step    = 1'b1;
                        cnt_d   = '0;
                        state_d = REPEAT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                REPEAT: begin
                    if (cnt_q == RATE_LAST) begin
                        step  = 1'b1;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prev_q  <= KEY_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prev_q  <= prev_d;
        end
    end

    assign key_class = w_class;

endmodule
`default_nettype wire

// File: rtl/cursor_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cursor_ctrl
// Brief    : Crossword grid cursor: position, entry direction and highlight
//            pixel coordinates driven by USB HID keycodes.
// Revision : 1.0
// ============================================================================
module cursor_ctrl
    import crossword_pkg::*;
#(
    parameter int GRID_COLS    = 15,
    parameter int GRID_ROWS    = 15,
    parameter int CELL_W       = 32,
    parameter int CELL_H       = 32,
    parameter int ORIGIN_X     = 0,
    parameter int ORIGIN_Y     = 0,
    parameter int WRAP         = 0,
    parameter int REPEAT_DELAY = 30,
    parameter int REPEAT_RATE  = 6
) (
    input  wire logic   frame_clk,
    input  wire logic   Reset_n,
    cursor_ctrl_if.slave bus
);

    localparam int COL_W = $clog2(GRID_COLS);
    localparam int ROW_W = $clog2(GRID_ROWS);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(GRID_COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(GRID_ROWS - 1);

    if ((ORIGIN_X + (GRID_COLS - 1) * CELL_W > 1023) ||
        (ORIGIN_Y + (GRID_ROWS - 1) * CELL_H > 1023)) begin : g_bad_geometry
        $error("cursor_ctrl: highlight position exceeds 10-bit range");
    end

    if ((REPEAT_RATE < 1) || (REPEAT_DELAY < 1)) begin : g_bad_repeat
        $error("cursor_ctrl: REPEAT_RATE and REPEAT_DELAY must be at least 1");
    end

    logic       w_step;
    key_class_t w_class;

    key_repeat #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_key_repeat (
        .frame_clk (frame_clk),
        .Reset_n   (Reset_n),
        .keycode   (bus.keycode),
        .step      (w_step),
        .key_class (w_class)
    );

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    dir_t             dir_q, dir_d;
    logic             move_pulse_q, move_pulse_d;

    logic w_right, w_left, w_down, w_up;

    always_comb begin
        w_right = 1'b0;
        w_left  = 1'b0;
        w_down  = 1'b0;
        w_up    = 1'b0;
        dir_d   = dir_q;
        if (w_step) begin
            case (w_class)
                KC_RIGHT:  w_right = 1'b1;
                KC_LEFT:   w_left  = 1'b1;
                KC_DOWN:   w_down  = 1'b1;
                KC_UP:     w_up    = 1'b1;
                KC_SPACE:  dir_d   = (dir_q == ACROSS) ? DOWN : ACROSS;
                KC_LETTER: begin
                    w_right = (dir_q == ACROSS);
                    w_down  = (dir_q == DOWN);
                end
                KC_BACK: begin
                    w_left = (dir_q == ACROSS);
                    w_up   = (dir_q == DOWN);
                end
                default: ;
            endcase
        end
    end

    // Edge moves either stay put (clamp) or wrap on the same axis only.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (w_right) begin
            if (col_q != COL_LAST)  col_d = col_q + 1'b1;
            else if (WRAP != 0)     col_d = '0;
        end
        if (w_left) begin
            if (col_q != '0)        col_d = col_q - 1'b1;
            else if (WRAP != 0)     col_d = COL_LAST;
        end
        if (w_down) begin
            if (row_q != ROW_LAST)  row_d = row_q + 1'b1;
            else if (WRAP != 0)     row_d = '0;
        end
        if (w_up) begin
            if (row_q != '0)        row_d = row_q - 1'b1;
            else if (WRAP != 0)     row_d = ROW_LAST;
        end
        move_pulse_d = (col_d != col_q) || (row_d != row_q);
    end

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            col_q        <= '0;
            row_q        <= '0;
            dir_q        <= ACROSS;
            move_pulse_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            dir_q        <= dir_d;
            move_pulse_q <= move_pulse_d;
        end
    end

    assign bus.col        = col_q;
    assign bus.row        = row_q;
    assign bus.dir        = (dir_q == DOWN);
    assign bus.move_pulse = move_pulse_q;
    assign bus.highlightX = HL_W'(ORIGIN_X + int'(col_q) * CELL_W);
    assign bus.highlightY = HL_W'(ORIGIN_Y + int'(row_q) * CELL_H);

endmodule
`default_nettype wire
